hex_stopwatch: RTL

Parametrised N-digit BCD stopwatch/counter with debounced pushbutton control and registered seven-segment outputs. It generalises the board-level 4-digit counter display: digit count, tick rate, debounce length, count direction and segment polarity are configurable, and it adds a lap/hold mode and a sticky wrap indicator. The block sits directly under the board top level, fed by raw KEY pins and driving the HEX displays.

---
 rtl/hex_pkg.sv | 32 +++
 rtl/key_debounce.sv | 49 ++++
 rtl/hex_stopwatch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hex_pkg.sv
// Shared types and helpers for the hex_stopwatch block: control states,
// the BCD digit type and the seven-segment lookup.
package hex_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  // Active-high {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg_encode(input bcd_t digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (accepted high-to-low change).
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the raw pin into the clock domain; idle level of a key is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= key_n;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else if (sync1 == stable) begin
      cnt   <= '0;
      press <= 1'b0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      stable <= sync1;
      cnt    <= '0;
      press  <= ~sync1;
    end else begin
      cnt   <= cnt + 1'b1;
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_stopwatch.sv
// N-digit BCD stopwatch with run/stop and clear/lap keys, a sticky wrap
// flag and registered seven-segment outputs.
module hex_stopwatch
  import hex_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 500_000,
  parameter int DEB_CYCLES     = 1_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_run_n,
  input  logic                  key_clr_n,
  input  logic                  dir_up,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  led_run,
  output logic                  led_wrap
);

  localparam int         PW       = $clog2(TICK_DIV);
  localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

  logic                 run_press;
  logic                 clr_press;
  logic                 dir_s0;
  logic                 dir_s1;
  sw_state_t            state_q;
  sw_state_t            state_d;
  logic                 do_clear;
  logic                 do_latch;
  logic                 running;
  logic                 tick;
  logic [PW-1:0]        presc_q;
  bcd_t [DIGITS-1:0]    count_q;
  bcd_t [DIGITS-1:0]    count_step;
  bcd_t [DIGITS-1:0]    held_q;
  bcd_t [DIGITS-1:0]    disp;
  logic                 wrap;
  logic                 wrap_flag;
  logic [7*DIGITS-1:0]  seg_next;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_run_n),
    .press (run_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clr_n),
    .press (clr_press)
  );

  // Direction switch only needs synchronising; it is sampled once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_s0 <= 1'b0;
      dir_s1 <= 1'b0;
    end else begin
      dir_s0 <= dir_up;
      dir_s1 <= dir_s0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STOP;
    else        state_q <= state_d;
  end

  // Key decoding; a run press always takes priority over a clear press.
  always_comb begin
    state_d  = state_q;
    do_clear = 1'b0;
    do_latch = 1'b0;
    case (state_q)
      STOP: begin
        if (run_press)      state_d  = RUN;
        else if (clr_press) do_clear = 1'b1;
      end
      RUN: begin
        if (run_press) begin
          state_d = STOP;
        end else if (clr_press) begin
          state_d  = HOLD;
          do_latch = 1'b1;
        end
      end
      HOLD: begin
        if (run_press)      state_d = STOP;
        else if (clr_press) state_d = RUN;
      end
      default: state_d = STOP;
    endcase
  end

  assign running = (state_q != STOP);
  assign tick    = running && (presc_q == PW'(TICK_DIV - 1));

  // Prescaler runs only while counting and keeps its phase across STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        presc_q <= '0;
    else if (do_clear) presc_q <= '0;
    else if (tick)     presc_q <= '0;
    else if (running)  presc_q <= presc_q + 1'b1;
  end

  // Next counter value: ripple carry (up) or borrow (down) across digits.
  always_comb begin
    count_step = count_q;
    wrap       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (wrap) begin
        if (dir_s1) begin
          if (count_q[i] == 4'd9) begin
            count_step[i] = 4'd0;
          end else begin
            count_step[i] = count_q[i] + 4'd1;
            wrap          = 1'b0;
          end
        end else begin
          if (count_q[i] == 4'd0) begin
            count_step[i] = 4'd9;
          end else begin
            count_step[i] = count_q[i] - 4'd1;
            wrap          = 1'b0;
          end
        end
      end
    end
  end

  // Counter and sticky wrap flag; clear zeroes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrap_flag <= 1'b0;
    end else if (do_clear) begin
      count_q   <= '0;
      wrap_flag <= 1'b0;
    end else if (tick) begin
      count_q <= count_step;
      if (wrap) wrap_flag <= 1'b1;
    end
  end

  // Lap latch captures the live value on entry to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        held_q <= '0;
    else if (do_latch) held_q <= count_q;
  end

  assign disp = (state_q == HOLD) ? held_q : count_q;

  // Segment patterns for the displayed value in the board's polarity.
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = SEG_ACTIVE_LOW ? ~seg_encode(disp[i]) : seg_encode(disp[i]);
    end
  end

  // Registered outputs so the pins never see combinational glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex      <= {DIGITS{SEG_ZERO}};
      led_run  <= 1'b0;
      led_wrap <= 1'b0;
    end else begin
      hex      <= seg_next;
      led_run  <= running;
      led_wrap <= wrap_flag;
    end
  end

endmodule
